mem_arbiter: RTL and testbench

Shares the single processor-to-memory port between the instruction-fetch requester (icache) and the data requester (dcache/LSQ). Arbitrates each cycle with dcache priority and bounded icache starvation. Records which requester owns every outstanding memory tag and routes each returning data block back to its owner. Sits between the two cache controllers and the memory model, below the fetch stage.

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Memory-port arbiter: dcache-priority request selection with bounded icache starvation,
// plus a per-tag owner table that routes each returning data block to the requester that issued it.
module mem_arbiter #(
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int BLOCK_W      = 64,
  parameter int TAG_W        = $clog2(NUM_TAGS),
  parameter int CMD_W        = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CMD_W-1:0]   icache_command,
  input  logic [ADDR_W-1:0]  icache_addr,
  input  logic [CMD_W-1:0]   dcache_command,
  input  logic [ADDR_W-1:0]  dcache_addr,
  input  logic [BLOCK_W-1:0] dcache_data,
  output logic               icache_grant,
  output logic               dcache_grant,
  output logic [TAG_W-1:0]   icache_transaction_tag,
  output logic [TAG_W-1:0]   dcache_transaction_tag,
  output logic [TAG_W-1:0]   icache_data_tag,
  output logic [TAG_W-1:0]   dcache_data_tag,
  output logic [BLOCK_W-1:0] icache_data,
  output logic [BLOCK_W-1:0] dcache_data_out,
  output logic [CMD_W-1:0]   proc2mem_command,
  output logic [ADDR_W-1:0]  proc2mem_addr,
  output logic [BLOCK_W-1:0] proc2mem_data,
  input  logic [TAG_W-1:0]   mem2proc_transaction_tag,
  input  logic [TAG_W-1:0]   mem2proc_data_tag,
  input  logic [BLOCK_W-1:0] mem2proc_data,
  output logic               orphan_resp
);

  localparam logic [CMD_W-1:0] MEM_NONE  = CMD_W'(0);
  localparam logic [CMD_W-1:0] MEM_LOAD  = CMD_W'(1);
  localparam logic [CMD_W-1:0] MEM_STORE = CMD_W'(2);
  localparam int               CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]    starve_q, starve_d;
  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;   // 0 = icache, 1 = dcache

  logic i_act, d_act, sel_i, sel_d, accept, i_grant, d_grant, rsp_hit;

  always_comb begin
    i_act   = icache_command != MEM_NONE;
    d_act   = dcache_command != MEM_NONE;
    // dcache wins ties unless icache has been denied STARVE_LIMIT times in a row
    sel_i   = i_act && (!d_act || starve_q == STARVE_MAX);
    sel_d   = d_act && !sel_i;
    accept  = mem2proc_transaction_tag != '0;
    i_grant = reset && sel_i && accept;
    d_grant = reset && sel_d && accept;
    rsp_hit = (mem2proc_data_tag != '0) && valid_q[mem2proc_data_tag];
  end

  always_comb begin
    icache_grant           = i_grant;
    dcache_grant           = d_grant;
    icache_transaction_tag = '0;
    dcache_transaction_tag = '0;
    icache_data_tag        = '0;
    dcache_data_tag        = '0;
    icache_data            = '0;
    dcache_data_out        = '0;
    proc2mem_command       = MEM_NONE;
    proc2mem_addr          = '0;
    proc2mem_data          = '0;
    orphan_resp            = 1'b0;
    if (reset) begin
      if (sel_i) begin
        proc2mem_command = icache_command;
        proc2mem_addr    = icache_addr;
      end else if (sel_d) begin
        proc2mem_command = dcache_command;
        proc2mem_addr    = dcache_addr;
        if (dcache_command == MEM_STORE) proc2mem_data = dcache_data;
      end
      if (i_grant) icache_transaction_tag = mem2proc_transaction_tag;
      if (d_grant) dcache_transaction_tag = mem2proc_transaction_tag;
      if (mem2proc_data_tag != '0) begin
        if (!rsp_hit) begin
          orphan_resp = 1'b1;
        end else if (owner_q[mem2proc_data_tag]) begin
          dcache_data_tag = mem2proc_data_tag;
          dcache_data_out = mem2proc_data;
        end else begin
          icache_data_tag = mem2proc_data_tag;
          icache_data     = mem2proc_data;
        end
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    valid_d  = valid_q;
    owner_d  = owner_q;
    if (i_act && !i_grant) begin
      if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
    end else begin
      starve_d = '0;
    end
    if (rsp_hit) valid_d[mem2proc_data_tag] = 1'b0;
    // Allocation comes after retirement so a same-cycle reuse of a tag keeps the new owner
    if ((i_grant && icache_command == MEM_LOAD) || (d_grant && dcache_command == MEM_LOAD)) begin
      valid_d[mem2proc_transaction_tag] = 1'b1;
      owner_d[mem2proc_transaction_tag] = d_grant;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
      valid_q  <= '0;
      owner_q  <= '0;
    end else begin
      starve_q <= starve_d;
      valid_q  <= valid_d;
      owner_q  <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked against a
// tag-ownership / denial-count reference model through an expected-output queue.
module tb_mem_arbiter;
  localparam int NT = 16;
  localparam int SL = 4;
  localparam int AW = 32;
  localparam int BW = 64;
  localparam int TW = 4;
  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  typedef struct packed {
    logic          ig;
    logic          dg;
    logic [TW-1:0] itt;
    logic [TW-1:0] dtt;
    logic [TW-1:0] idt;
    logic [TW-1:0] ddt;
    logic [BW-1:0] idat;
    logic [BW-1:0] ddat;
    logic [1:0]    pcmd;
    logic [AW-1:0] paddr;
    logic [BW-1:0] pdat;
    logic          orphan;
  } resp_t;
  localparam int RW = $bits(resp_t);

  logic          clock;
  logic          reset;
  logic [1:0]    icache_command, dcache_command, proc2mem_command;
  logic [AW-1:0] icache_addr, dcache_addr, proc2mem_addr;
  logic [BW-1:0] dcache_data, icache_data, dcache_data_out, proc2mem_data, mem2proc_data;
  logic          icache_grant, dcache_grant, orphan_resp;
  logic [TW-1:0] icache_transaction_tag, dcache_transaction_tag;
  logic [TW-1:0] icache_data_tag, dcache_data_tag;
  logic [TW-1:0] mem2proc_transaction_tag, mem2proc_data_tag;

  logic [RW-1:0] exp_q[$];
  int total;
  int bad;
  int owner_of[int];   // outstanding load tag -> 0 icache / 1 dcache
  int denied;          // consecutive cycles icache asked and was not granted (saturating)

  mem_arbiter #(.NUM_TAGS(NT), .STARVE_LIMIT(SL), .ADDR_W(AW), .BLOCK_W(BW)) dut (
    .clock(clock), .reset(reset),
    .icache_command(icache_command), .icache_addr(icache_addr),
    .dcache_command(dcache_command), .dcache_addr(dcache_addr), .dcache_data(dcache_data),
    .icache_grant(icache_grant), .dcache_grant(dcache_grant),
    .icache_transaction_tag(icache_transaction_tag), .dcache_transaction_tag(dcache_transaction_tag),
    .icache_data_tag(icache_data_tag), .dcache_data_tag(dcache_data_tag),
    .icache_data(icache_data), .dcache_data_out(dcache_data_out),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_transaction_tag(mem2proc_transaction_tag), .mem2proc_data_tag(mem2proc_data_tag),
    .mem2proc_data(mem2proc_data), .orphan_resp(orphan_resp)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // driver: applies one cycle of inputs and pushes the model's expected outputs
  task automatic drive(input logic rst, input logic [1:0] ic, input logic [AW-1:0] ia,
                       input logic [1:0] dc, input logic [AW-1:0] da, input logic [BW-1:0] dd,
                       input logic [TW-1:0] tt, input logic [TW-1:0] dt, input logic [BW-1:0] md);
    resp_t e;
    int    pick;
    logic  granted;
    @(posedge clock);
    #1;
    reset = rst;
    icache_command = ic;  icache_addr = ia;
    dcache_command = dc;  dcache_addr = da;  dcache_data = dd;
    mem2proc_transaction_tag = tt;  mem2proc_data_tag = dt;  mem2proc_data = md;
    e = '0;
    if (!rst) begin
      owner_of.delete();
      denied = 0;
    end else begin
      pick = 0;
      if (ic != C_NONE && dc != C_NONE) pick = (denied == SL) ? 1 : 2;
      else if (ic != C_NONE) pick = 1;
      else if (dc != C_NONE) pick = 2;
      granted = (pick != 0) && (tt != 0);
      if (pick == 1) begin e.pcmd = ic; e.paddr = ia; end
      if (pick == 2) begin
        e.pcmd = dc; e.paddr = da;
        if (dc == C_STORE) e.pdat = dd;
      end
      if (granted && pick == 1) begin e.ig = 1'b1; e.itt = tt; end
      if (granted && pick == 2) begin e.dg = 1'b1; e.dtt = tt; end
      if (dt != 0) begin
        if (owner_of.exists(int'(dt))) begin
          if (owner_of[int'(dt)] == 0) begin e.idt = dt; e.idat = md; end
          else begin e.ddt = dt; e.ddat = md; end
          owner_of.delete(int'(dt));
        end else begin
          e.orphan = 1'b1;
        end
      end
      if (granted && ((pick == 1 && ic == C_LOAD) || (pick == 2 && dc == C_LOAD)))
        owner_of[int'(tt)] = pick - 1;
      if (ic != C_NONE && !(granted && pick == 1)) denied = (denied < SL) ? denied + 1 : SL;
      else denied = 0;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [TW-1:0] dt, input logic [BW-1:0] md);
    drive(1'b1, C_NONE, '0, C_NONE, '0, '0, '0, dt, md);
  endtask

  // monitor: one expected output set per driven cycle, compared mid-cycle
  initial begin
    logic [RW-1:0] want;
    logic [RW-1:0] got;
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got = {icache_grant, dcache_grant, icache_transaction_tag, dcache_transaction_tag,
               icache_data_tag, dcache_data_tag, icache_data, dcache_data_out,
               proc2mem_command, proc2mem_addr, proc2mem_data, orphan_resp};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL outputs cyc=%0d got=%h want=%h", n, got, want);
        end
        n++;
      end
    end
  end

  initial begin
    total = 0; bad = 0; denied = 0;
    reset = 1'b0;
    icache_command = C_NONE; icache_addr = '0;
    dcache_command = C_NONE; dcache_addr = '0; dcache_data = '0;
    mem2proc_transaction_tag = '0; mem2proc_data_tag = '0; mem2proc_data = '0;

    repeat (3) drive(1'b0, C_NONE, '0, C_NONE, '0, '0, '0, '0, '0);
    repeat (2) idle('0, '0);

    // single icache load, data back 10 cycles later
    drive(1'b1, C_LOAD, 32'h100, C_NONE, '0, '0, 4'd2, '0, '0);
    #2;
    check("ld_igrant", icache_grant, 1);
    check("ld_itag", icache_transaction_tag, 2);
    check("ld_paddr", proc2mem_addr, 32'h100);
    repeat (9) idle('0, '0);
    idle(4'd2, 64'hDEAD);
    #2;
    check("ld_idt", icache_data_tag, 2);
    check("ld_idata", icache_data, 64'hDEAD);
    check("ld_ddt", dcache_data_tag, 0);
    check("ld_ddata", dcache_data_out, 0);

    // both active, memory always accepts: D,D,D,D,I repeating
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, C_LOAD, 32'h200, C_LOAD, 32'h300, '0, 4'(8 + i % 5), '0, '0);
      #2;
      check($sformatf("pat_i%0d", i), icache_grant, (i % 5 == 4) ? 1 : 0);
      check($sformatf("pat_d%0d", i), dcache_grant, (i % 5 == 4) ? 0 : 1);
    end
    idle('0, '0);

    // three rejected cycles, accepted on the fourth
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, C_LOAD, 32'h400, C_NONE, '0, '0, (i < 3) ? 4'd0 : 4'd6, '0, '0);
      #2;
      check($sformatf("rej_g%0d", i), icache_grant, (i == 3) ? 1 : 0);
    end

    // store is not tracked; its tag comes back orphaned
    drive(1'b1, C_NONE, '0, C_STORE, 32'h500, 64'hCAFEF00D12345678, 4'd7, '0, '0);
    #2;
    check("st_pdata", proc2mem_data, 64'hCAFEF00D12345678);
    check("st_pcmd", proc2mem_command, C_STORE);
    check("st_dtag", dcache_transaction_tag, 7);
    idle(4'd7, 64'h77);
    #2;
    check("st_orphan", orphan_resp, 1);
    check("st_ddt", dcache_data_tag, 0);

    // tag 4 retires to dcache while icache reallocates it
    drive(1'b1, C_NONE, '0, C_LOAD, 32'h600, '0, 4'd4, '0, '0);
    #2;
    check("t4_dgrant", dcache_grant, 1);
    drive(1'b1, C_LOAD, 32'h700, C_NONE, '0, '0, 4'd4, 4'd4, 64'h1111);
    #2;
    check("t4_ddt", dcache_data_tag, 4);
    check("t4_ddata", dcache_data_out, 64'h1111);
    check("t4_igrant", icache_grant, 1);
    idle(4'd4, 64'h2222);
    #2;
    check("t4_idt", icache_data_tag, 4);
    check("t4_idata", icache_data, 64'h2222);
    check("t4_orphan", orphan_resp, 0);

    // reset with tags 3 and 5 in flight
    drive(1'b1, C_LOAD, 32'h800, C_LOAD, 32'h900, '0, 4'd3, '0, '0);
    drive(1'b1, C_LOAD, 32'h800, C_NONE, '0, '0, 4'd5, '0, '0);
    drive(1'b0, C_LOAD, 32'h800, C_STORE, 32'h900, 64'h55, 4'd9, 4'd3, 64'h33);
    #2;
    check("rst_pcmd", proc2mem_command, C_NONE);
    check("rst_pdata", proc2mem_data, 0);
    check("rst_igrant", icache_grant, 0);
    check("rst_ddt", dcache_data_tag, 0);
    check("rst_orphan", orphan_resp, 0);
    idle(4'd3, 64'h33);
    #2;
    check("post_rst_orphan", orphan_resp, 1);
    check("post_rst_ddt", dcache_data_tag, 0);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [1:0]    ic, dc;
      logic [TW-1:0] tt, dt;
      logic          rst;
      int            keys[$];
      keys.delete();
      foreach (owner_of[k]) keys.push_back(k);
      ic  = ($urandom_range(0, 9) < 6) ? C_LOAD : C_NONE;
      dc  = 2'($urandom_range(0, 2));
      tt  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, NT - 1));
      rst = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 1) == 0) dt = '0;
      else if (keys.size() > 0 && $urandom_range(0, 9) < 7)
        dt = 4'(keys[$urandom_range(0, keys.size() - 1)]);
      else dt = 4'($urandom_range(1, NT - 1));
      drive(rst, ic, $urandom, dc, $urandom, {$urandom, $urandom}, tt, dt, {$urandom, $urandom});
    end

    @(negedge clock);
    #1;
    check("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
